hq_metric_selector: RTL and testbench

//  Downstream of the H*S_q complex multiplier. Consumes its stream of 16 candidate 4x2 products
//  Hq (8 complex elements each, fixed-point Q fractional bits).

---
 rtl/hq_metric_selector.sv | 132 +++++++++++++
 tb/tb_hq_metric_selector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hq_metric_selector.sv
// Frobenius-energy metric per 4x2 Hq candidate and arg-max selection over a 16-candidate run.
// Metrics are saturating Q-format sums of |Hq_ij|^2; ties keep the lower candidate index.
module hq_metric_selector #(
  parameter int unsigned Q         = 8,
  parameter int unsigned N         = 16,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hq_in_valid,
  input  logic signed [N-1:0]  hq_in_r,
  input  logic signed [N-1:0]  hq_in_i,
  input  logic                 hq_one_matrix_done,
  input  logic                 all_16_hq_done,
  output logic                 metric_valid,
  output logic [ACC_WIDTH-1:0] metric_out,
  output logic [3:0]           metric_idx,
  output logic                 sel_valid,
  output logic [3:0]           sel_index,
  output logic [ACC_WIDTH-1:0] sel_metric,
  output logic                 busy,
  output logic                 sync_err
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StResult} state_t;

  state_t               state, state_next;
  logic [2:0]           elem_cnt;
  logic [3:0]           cand_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] best_metric;
  logic [3:0]           best_idx;

  logic signed [PW-1:0] prod_r, prod_i;
  logic [PW:0]          pow_sum;
  logic [PW-1:0]        sq;
  logic [SW-1:0]        acc_sum;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic                 elem_in, close, framing_bad, cmp_take;
  logic [ACC_WIDTH-1:0] cmp_metric;
  logic [3:0]           cmp_idx;

  // One extra bit keeps 2*(-32768)^2 from wrapping before the shift.
  assign prod_r  = hq_in_r * hq_in_r;
  assign prod_i  = hq_in_i * hq_in_i;
  assign pow_sum = {1'b0, prod_r} + {1'b0, prod_i};
  assign sq      = PW'(pow_sum >> Q);
  assign acc_sum = SW'(acc) + SW'(sq);
  assign acc_sat = (|acc_sum[SW-1:ACC_WIDTH]) ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

  assign elem_in     = (state == StRun) && hq_in_valid && !start;
  assign close       = elem_in && (elem_cnt == 3'd7);
  assign framing_bad = (hq_one_matrix_done && (elem_cnt != 3'd7)) ||
                       (all_16_hq_done && ((cand_cnt != 4'd15) || (elem_cnt != 3'd7)));
  assign busy        = (state != StIdle);

  // Candidate 0 always seeds the running best, so stale best values never win.
  always_comb begin
    cmp_take   = (metric_out > best_metric) || (metric_idx == 4'd0);
    cmp_metric = cmp_take ? metric_out : best_metric;
    cmp_idx    = cmp_take ? metric_idx : best_idx;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:   state_next = StIdle;
      StRun:    if (metric_valid && (metric_idx == 4'd15)) state_next = StResult;
      StResult: state_next = StIdle;
      default:  state_next = StIdle;
    endcase
    if (start) state_next = StRun;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      elem_cnt     <= '0;
      cand_cnt     <= '0;
      acc          <= '0;
      best_metric  <= '0;
      best_idx     <= '0;
      metric_valid <= 1'b0;
      metric_out   <= '0;
      metric_idx   <= '0;
      sel_valid    <= 1'b0;
      sel_index    <= '0;
      sel_metric   <= '0;
      sync_err     <= 1'b0;
    end else begin
      state        <= state_next;
      metric_valid <= close;
      sel_valid    <= 1'b0;
      if (start) begin
        elem_cnt    <= '0;
        cand_cnt    <= '0;
        acc         <= '0;
        best_metric <= '0;
        best_idx    <= '0;
        sync_err    <= 1'b0;
      end else begin
        if (elem_in) begin
          if (close) begin
            metric_out <= acc_sat;
            metric_idx <= cand_cnt;
            acc        <= '0;
            elem_cnt   <= '0;
            cand_cnt   <= cand_cnt + 4'd1;
          end else begin
            acc      <= acc_sat;
            elem_cnt <= elem_cnt + 3'd1;
          end
          if (framing_bad) sync_err <= 1'b1;
        end
        if ((state == StRun) && metric_valid) begin
          best_metric <= cmp_metric;
          best_idx    <= cmp_idx;
          if (metric_idx == 4'd15) begin
            sel_valid  <= 1'b1;
            sel_index  <= cmp_idx;
            sel_metric <= cmp_metric;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hq_metric_selector.sv
// Directed bench for hq_metric_selector: a default instance plus a 24-bit accumulator instance
// sharing the same stimulus, checked with immediate assertions.
module tb_hq_metric_selector;

  logic        clk = 1'b0;
  logic        rst, start, hq_in_valid, hq_one_matrix_done, all_16_hq_done;
  logic [15:0] hq_in_r, hq_in_i;

  logic        metric_valid, sel_valid, busy, sync_err;
  logic [31:0] metric_out, sel_metric;
  logic [3:0]  metric_idx, sel_index;

  logic        metric_valid24, sel_valid24, busy24, sync_err24;
  logic [23:0] metric_out24, sel_metric24;
  logic [3:0]  metric_idx24, sel_index24;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int sel_cnt = 0;
  int mv_base, sel_base;
  logic [31:0] met [16];

  hq_metric_selector u_dut (
    .clk(clk), .rst(rst), .start(start), .hq_in_valid(hq_in_valid),
    .hq_in_r(hq_in_r), .hq_in_i(hq_in_i),
    .hq_one_matrix_done(hq_one_matrix_done), .all_16_hq_done(all_16_hq_done),
    .metric_valid(metric_valid), .metric_out(metric_out), .metric_idx(metric_idx),
    .sel_valid(sel_valid), .sel_index(sel_index), .sel_metric(sel_metric),
    .busy(busy), .sync_err(sync_err)
  );

  hq_metric_selector #(.ACC_WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .start(start), .hq_in_valid(hq_in_valid),
    .hq_in_r(hq_in_r), .hq_in_i(hq_in_i),
    .hq_one_matrix_done(hq_one_matrix_done), .all_16_hq_done(all_16_hq_done),
    .metric_valid(metric_valid24), .metric_out(metric_out24), .metric_idx(metric_idx24),
    .sel_valid(sel_valid24), .sel_index(sel_index24), .sel_metric(sel_metric24),
    .busy(busy24), .sync_err(sync_err24)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (metric_valid) begin
      met[metric_idx] = metric_out;
      mv_cnt++;
    end
    if (sel_valid) sel_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: all 1.0; mode 1: candidate 9 at r=i=2.0; mode 2: r=i=-32768
  task automatic send(input int mode, input int first, input int last, input int err_at);
    for (int k = first; k <= last; k++) begin
      if (mode == 2) begin
        hq_in_r = 16'h8000;
        hq_in_i = 16'h8000;
      end else if (mode == 1 && k / 8 == 9) begin
        hq_in_r = 16'h0200;
        hq_in_i = 16'h0200;
      end else begin
        hq_in_r = 16'h0100;
        hq_in_i = 16'h0000;
      end
      hq_in_valid        = 1'b1;
      hq_one_matrix_done = (k % 8 == 7) || (k == err_at);
      all_16_hq_done     = (k == 127);
      @(negedge clk);
    end
    hq_in_valid        = 1'b0;
    hq_one_matrix_done = 1'b0;
    all_16_hq_done     = 1'b0;
  endtask

  // Called right after the 128th strobe's capturing edge (cycle T+1).
  task automatic finish_run(input string tag);
    chk({tag, "_mv_t1"}, {31'd0, metric_valid}, 32'd1);
    chk({tag, "_sel_t1"}, {31'd0, sel_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_sel_t2"}, {31'd0, sel_valid}, 32'd1);
    chk({tag, "_busy_t2"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_sel_t3"}, {31'd0, sel_valid}, 32'd0);
    chk({tag, "_busy_t3"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hq_in_valid = 1'b0;
    hq_one_matrix_done = 1'b0; all_16_hq_done = 1'b0;
    hq_in_r = '0; hq_in_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_metric_valid", {31'd0, metric_valid}, 32'd0);
    chk("rst_sel_valid", {31'd0, sel_valid}, 32'd0);
    chk("rst_sel_metric", sel_metric, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all equal metrics 8 * 1.0 = 0x800, tie -> index 0
    do_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    mv_base = mv_cnt; sel_base = sel_cnt;
    send(0, 0, 127, -1);
    finish_run("t1");
    chk("t1_sel_index", {28'd0, sel_index}, 32'd0);
    chk("t1_sel_metric", sel_metric, 32'h800);
    chk("t1_met0", met[0], 32'h800);
    chk("t1_met15", met[15], 32'h800);
    chk("t1_mv_count", mv_cnt - mv_base, 32'd16);
    chk("t1_sel_count", sel_cnt - sel_base, 32'd1);
    chk("t1_sync_err", {31'd0, sync_err}, 32'd0);

    // 2: candidate 9 elements (4+4)*2^16 >> 8 = 0x800 each -> 0x4000
    do_start();
    send(1, 0, 127, -1);
    finish_run("t2");
    chk("t2_sel_index", {28'd0, sel_index}, 32'd9);
    chk("t2_sel_metric", sel_metric, 32'h4000);
    chk("t2_met9", met[9], 32'h4000);
    chk("t2_met8", met[8], 32'h800);
    chk("t2_sel24", {8'd0, sel_metric24}, 32'h4000);

    // 3: 2*(-32768)^2 >> 8 = 0x800000 per element -> 0x4000000; 24-bit saturates
    do_start();
    send(2, 0, 127, -1);
    finish_run("t3");
    chk("t3_met3", met[3], 32'h4000000);
    chk("t3_sel_metric", sel_metric, 32'h4000000);
    chk("t3_sel_index", {28'd0, sel_index}, 32'd0);
    chk("t3_sel24", {8'd0, sel_metric24}, 32'hFFFFFF);

    // 4: early end-of-candidate flag on 5th element
    do_start();
    chk("t4_sync_clear", {31'd0, sync_err}, 32'd0);
    mv_base = mv_cnt; sel_base = sel_cnt;
    send(0, 0, 4, 4);
    chk("t4_sync_set", {31'd0, sync_err}, 32'd1);
    send(0, 5, 127, -1);
    finish_run("t4");
    chk("t4_sync_sticky", {31'd0, sync_err}, 32'd1);
    chk("t4_mv_count", mv_cnt - mv_base, 32'd16);
    chk("t4_met0", met[0], 32'h800);
    chk("t4_sel_metric", sel_metric, 32'h800);

    // 5: reset at element 60, then a clean run
    do_start();
    sel_base = sel_cnt;
    send(0, 0, 59, -1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_sel_metric", sel_metric, 32'd0);
    chk("t5_rst_metric_out", metric_out, 32'd0);
    chk("t5_rst_sync", {31'd0, sync_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_sel_aborted", sel_cnt - sel_base, 32'd0);
    do_start();
    send(1, 0, 126, -1);
    chk("t5_no_sel_early", sel_cnt - sel_base, 32'd0);
    send(1, 127, 127, -1);
    finish_run("t5");
    chk("t5_sel_count", sel_cnt - sel_base, 32'd1);
    chk("t5_sel_index", {28'd0, sel_index}, 32'd9);
    chk("t5_sel_metric", sel_metric, 32'h4000);

    // 6: restart inside candidate 7, then strobes while idle must be ignored
    do_start();
    sel_base = sel_cnt;
    send(2, 0, 59, -1);
    do_start();
    mv_base = mv_cnt;
    send(0, 0, 127, -1);
    finish_run("t6");
    chk("t6_sel_count", sel_cnt - sel_base, 32'd1);
    chk("t6_mv_count", mv_cnt - mv_base, 32'd16);
    chk("t6_sel_metric", sel_metric, 32'h800);
    chk("t6_met7", met[7], 32'h800);
    send(2, 0, 9, -1);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    send(1, 0, 127, -1);
    finish_run("t6b");
    chk("t6b_sel_index", {28'd0, sel_index}, 32'd9);
    chk("t6b_sel_metric", sel_metric, 32'h4000);
    chk("t6b_met0", met[0], 32'h800);
    chk("t6b_sel_count", sel_cnt - sel_base, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
